// File: rtl/mem_access_unit.sv
`timescale 1ns/1ps
// mem_access_unit
// Data-memory responder for the core's load/store controls. It accepts one
// word request over a valid/ready handshake and inserts WAIT_CYCLES wait
// states. It then returns a one-cycle resp_valid pulse carrying the load data.
// The word array is internal. While busy is high the datapath has to stall.
//
// Optional build macro: MEM_ALIGN_CHECK_EN
//   defined   : a load or store with addr[1:0]!=0 skips the array access and
//               raises err for its resp_valid cycle (rdata=0)
//   undefined : err is always 0 and addr[1:0] is ignored
//
// Ports
//   clk, rst          system clock, asynchronous active-high reset
//   req_valid/ready   request handshake (ready only in IDLE, low during rst)
//   mem_read, we_mem  load / store qualifiers (store wins when both are high)
//   addr, wdata       byte address and store data, latched on accept
//   resp_valid        one-cycle completion pulse
//   rdata             load data, held until the next response
//   busy              transaction in flight
//   err               misaligned access flag (optional feature)
//
// state | meaning
// IDLE  | ready for a request
// WAIT  | counting down wait states
// RESP  | response cycle, resp_valid high
module mem_access_unit #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              mem_read,
    input  logic              we_mem,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              err
);
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              ld_q, ld_d;
    logic              st_q, st_d;
    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              accept;
    logic              enter_resp;
    logic [ADDR_W-1:0] eff_addr;
    logic [DATA_W-1:0] eff_wdata;
    logic              eff_ld;
    logic              eff_st;
    logic [IDX_W-1:0]  eff_idx;
    logic              misalign;
    logic              do_write;
    logic              unused_addr_bits;

    assign req_ready = (state_q == S_IDLE) && !rst;
    assign busy      = (state_q != S_IDLE);
    assign accept    = req_valid && req_ready;

    // The eff_* request fields are the latched request. With zero wait states
    // the array access happens on the accept edge itself, so the live inputs
    // are used in that one case.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        ld_d       = ld_q;
        st_d       = st_q;
        enter_resp = 1'b0;
        eff_addr   = addr_q;
        eff_wdata  = wdata_q;
        eff_ld     = ld_q;
        eff_st     = st_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    addr_d  = addr;
                    wdata_d = wdata;
                    st_d    = we_mem;
                    ld_d    = mem_read && !we_mem;
                    cnt_d   = 4'(WAIT_CYCLES);
                    if (WAIT_CYCLES == 0) begin
                        state_d    = S_RESP;
                        enter_resp = 1'b1;
                        eff_addr   = addr;
                        eff_wdata  = wdata;
                        eff_st     = we_mem;
                        eff_ld     = mem_read && !we_mem;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d    = S_RESP;
                    enter_resp = 1'b1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign eff_idx = eff_addr[IDX_W+1:2];
    assign unused_addr_bits = ^{eff_addr[ADDR_W-1:IDX_W+2], eff_addr[1:0]};

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign = (eff_ld || eff_st) && (eff_addr[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    assign do_write = enter_resp && eff_st && !misalign && !rst;

    always_comb begin
        rdata_d      = rdata_q;
        resp_valid_d = enter_resp;
        err_d        = enter_resp && misalign;
        if (enter_resp) begin
            rdata_d = (eff_ld && !misalign) ? mem[eff_idx] : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            ld_q         <= 1'b0;
            st_q         <= 1'b0;
            resp_valid_q <= 1'b0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            ld_q         <= ld_d;
            st_q         <= st_d;
            resp_valid_q <= resp_valid_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
        end
    end

    // The array has no reset. A store commits only on the edge entering RESP.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[eff_idx] <= eff_wdata;
        end
    end

    assign resp_valid = resp_valid_q;
    assign rdata      = rdata_q;
    assign err        = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
`timescale 1ns/1ps
module tb_mem_access_unit;
    localparam int WAIT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, mem_read, we_mem;
    logic [31:0] addr, wdata;
    logic        req_ready, resp_valid, busy, err;
    logic [31:0] rdata;

    logic        z_valid, z_read, z_we;
    logic [31:0] z_addr, z_wdata;
    logic        z_ready, z_resp, z_busy, z_err;
    logic [31:0] z_rdata;

    mem_access_unit #(.ADDR_W(32), .DATA_W(32), .DEPTH(256), .WAIT_CYCLES(WAIT)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .mem_read(mem_read), .we_mem(we_mem), .addr(addr), .wdata(wdata),
        .resp_valid(resp_valid), .rdata(rdata), .busy(busy), .err(err)
    );

    mem_access_unit #(.ADDR_W(32), .DATA_W(32), .DEPTH(256), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst), .req_valid(z_valid), .req_ready(z_ready),
        .mem_read(z_read), .we_mem(z_we), .addr(z_addr), .wdata(z_wdata),
        .resp_valid(z_resp), .rdata(z_rdata), .busy(z_busy), .err(z_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;

`ifdef MEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every response must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (resp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_resp", {31'b0, resp_valid}, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("resp_rdata", rdata, mon_e.rdata);
                    chk("resp_err", {31'b0, err}, {31'b0, mon_e.err});
                end
            end else begin
                chk("err_outside_resp", {31'b0, err}, 32'd0);
            end
        end
    end

    task automatic do_req(input string name, input logic rd, input logic we,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] exp_rd, input logic exp_err,
                          input bit stall);
        int   lat;
        exp_t e;
        @(negedge clk);
        chk({name, "_ready"}, {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1; mem_read = rd; we_mem = we; addr = a; wdata = d;
        e.rdata = exp_rd; e.err = exp_err;
        exp_q.push_back(e);
        @(posedge clk); #1;
        if (stall) begin
            mem_read = 1'b0; we_mem = 1'b1; addr = 32'h30; wdata = 32'hBAD0BAD0;
        end else begin
            req_valid = 1'b0; mem_read = 1'b0; we_mem = 1'b0;
        end
        lat = 0;
        while (!resp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({name, "_latency"}, 32'(lat), 32'(WAIT));
        @(posedge clk); #1;
        chk({name, "_ready_after"}, {31'b0, req_ready}, 32'd1);
        chk({name, "_resp_low"}, {31'b0, resp_valid}, 32'd0);
        chk({name, "_rdata_held"}, rdata, exp_rd);
        req_valid = 1'b0; mem_read = 1'b0; we_mem = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b1; req_valid = 1'b0; mem_read = 1'b0; we_mem = 1'b0;
        addr = '0; wdata = '0;
        z_valid = 1'b0; z_read = 1'b0; z_we = 1'b0; z_addr = '0; z_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("ready_in_reset", {31'b0, req_ready}, 32'd0);
        @(negedge clk); rst = 1'b0; #1;
        chk("rst_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_resp", {31'b0, resp_valid}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);

        do_req("st10", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0);
        do_req("ld10", 1'b1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0);
        do_req("st400", 1'b0, 1'b1, 32'h400, 32'h12345678, 32'h0, 1'b0, 1'b0);
        do_req("ld0", 1'b1, 1'b0, 32'h0, 32'h0, 32'h12345678, 1'b0, 1'b0);
        do_req("both20", 1'b1, 1'b1, 32'h20, 32'hA5A5A5A5, 32'h0, 1'b0, 1'b0);
        do_req("ld20a", 1'b1, 1'b0, 32'h20, 32'h0, 32'hA5A5A5A5, 1'b0, 1'b0);
        do_req("nop20", 1'b0, 1'b0, 32'h20, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0);
        do_req("ld20b", 1'b1, 1'b0, 32'h20, 32'h0, 32'hA5A5A5A5, 1'b0, 1'b0);

        do_req("st30", 1'b0, 1'b1, 32'h30, 32'h11111111, 32'h0, 1'b0, 1'b0);
        do_req("ld10_stall", 1'b1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);
        do_req("ld30", 1'b1, 1'b0, 32'h30, 32'h0, 32'h11111111, 1'b0, 1'b0);

        // Reset during WAIT aborts the pending store.
        do_req("st40", 1'b0, 1'b1, 32'h40, 32'h0BADF00D, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        req_valid = 1'b1; we_mem = 1'b1; addr = 32'h40; wdata = 32'hFFFFFFFF;
        @(posedge clk); #1;
        req_valid = 1'b0; we_mem = 1'b0;
        chk("abort_busy_before", {31'b0, busy}, 32'd1);
        @(negedge clk); rst = 1'b1; #1;
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_ready", {31'b0, req_ready}, 32'd0);
        chk("abort_resp", {31'b0, resp_valid}, 32'd0);
        @(negedge clk); rst = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            chk("abort_no_resp", {31'b0, resp_valid}, 32'd0);
        end
        chk("abort_rdata", rdata, 32'd0);
        do_req("ld40", 1'b1, 1'b0, 32'h40, 32'h0, 32'h0BADF00D, 1'b0, 1'b0);

        do_req("st22", 1'b0, 1'b1, 32'h22, 32'h5A5A5A5A, 32'h0, ALIGN, 1'b0);
        do_req("ld20c", 1'b1, 1'b0, 32'h20, 32'h0,
               ALIGN ? 32'hA5A5A5A5 : 32'h5A5A5A5A, 1'b0, 1'b0);
        do_req("nop22", 1'b0, 1'b0, 32'h22, 32'h0, 32'h0, 1'b0, 1'b0);
        do_req("ld22", 1'b1, 1'b0, 32'h22, 32'h0,
               ALIGN ? 32'h0 : 32'h5A5A5A5A, ALIGN, 1'b0);

        // Zero wait-state instance: response right after the accept edge.
        @(negedge clk);
        chk("z_ready", {31'b0, z_ready}, 32'd1);
        z_valid = 1'b1; z_we = 1'b1; z_addr = 32'h8; z_wdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        z_valid = 1'b0; z_we = 1'b0;
        chk("z_st_resp", {31'b0, z_resp}, 32'd1);
        chk("z_st_rdata", z_rdata, 32'd0);
        @(posedge clk); #1;
        chk("z_st_resp_low", {31'b0, z_resp}, 32'd0);
        chk("z_st_ready", {31'b0, z_ready}, 32'd1);
        @(negedge clk);
        z_valid = 1'b1; z_read = 1'b1; z_addr = 32'h8;
        @(posedge clk); #1;
        z_valid = 1'b0; z_read = 1'b0;
        chk("z_ld_resp", {31'b0, z_resp}, 32'd1);
        chk("z_ld_rdata", z_rdata, 32'hCAFEF00D);
        @(posedge clk); #1;
        chk("z_ld_resp_low", {31'b0, z_resp}, 32'd0);

        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
